// File: rtl/j68_pkg.sv
// ============================================================================
// j68_pkg
// Shared micro-sequencer types: micro-address width, opcodes, FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package j68_pkg;

    localparam int UA_W = 11;

    localparam logic [2:0] OP_LOOP   = 3'b000;
    localparam logic [2:0] OP_JMP    = 3'b001;
    localparam logic [2:0] OP_CALL   = 3'b010;
    localparam logic [2:0] OP_RET    = 3'b011;
    localparam logic [2:0] OP_DECODE = 3'b100;
    localparam logic [2:0] OP_HALT   = 3'b101;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } useq_state_t;

endpackage

`default_nettype wire

// File: rtl/j68_rstack.sv
// ============================================================================
// j68_rstack
// Register-based return-address LIFO with sticky overflow/underflow error.
// Revision: 1.0
// ============================================================================
`default_nettype none

module j68_rstack
    import j68_pkg::*;
#(
    parameter int              DEPTH   = 8,
    parameter logic [UA_W-1:0] RST_VEC = 11'h000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [UA_W-1:0] push_data,
    output logic [UA_W-1:0] pop_data,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]   ptr;
    logic [IW-1:0]   top_idx;
    logic [IW-1:0]   wr_idx;
    logic [UA_W-1:0] mem [DEPTH];

    assign full     = (ptr == PW'(DEPTH));
    assign empty    = (ptr == '0);
    assign top_idx  = IW'(ptr - PW'(1));
    // A push into a full stack lands on the current top entry.
    assign wr_idx   = full ? top_idx : ptr[IW-1:0];
    assign pop_data = empty ? RST_VEC : mem[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            err <= 1'b0;
        end else if (push) begin
            if (full) err <= 1'b1;
            else      ptr <= ptr + PW'(1);
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else       ptr <= ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/j68_useq.sv
// ============================================================================
// j68_useq
// Microcode sequencer: next micro-ROM address, return stack, halt/exception.
// Revision: 1.0
// ============================================================================
`default_nettype none

module j68_useq
    import j68_pkg::*;
#(
    parameter int              STK_DEPTH = 8,
    parameter logic [UA_W-1:0] RST_VEC   = 11'h000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_ena,
    input  logic [19:0]     inst_in,
    input  logic            loop_branch,
    input  logic            loop_skip,
    input  logic [UA_W-1:0] loop_pc,
    input  logic [UA_W-1:0] dec_addr,
    input  logic            cond,
    input  logic            exc_req,
    input  logic [UA_W-1:0] exc_vec,
    input  logic            resume,
    output logic [UA_W-1:0] rom_addr,
    output logic [UA_W-1:0] upc,
    output logic            i_fetch,
    output logic            exc_ack,
    output logic            stk_err
);

    useq_state_t     state;
    logic [2:0]      op;
    logic [UA_W-1:0] target;
    logic [UA_W-1:0] upc_inc;
    logic [UA_W-1:0] nxt;
    logic [UA_W-1:0] pop_data;
    logic            call_req;
    logic            ret_req;
    logic            exc_take;
    logic            halt_req;
    logic            stk_full;
    logic            stk_empty;
    logic            unused_bits;

    assign op          = inst_in[19:17];
    assign target      = inst_in[UA_W-1:0];
    assign upc_inc     = upc + UA_W'(1);
    assign unused_bits = ^{inst_in[16:12], stk_full, stk_empty};

    // Loop branch outranks everything, so it also suppresses CALL/RET stack traffic.
    always_comb begin
        nxt      = upc_inc;
        call_req = 1'b0;
        ret_req  = 1'b0;
        exc_take = 1'b0;
        halt_req = 1'b0;
        if (loop_branch) begin
            nxt = loop_pc;
        end else if (op == OP_LOOP && loop_skip) begin
            nxt = target + UA_W'(1);
        end else begin
            case (op)
                OP_JMP:    if (!inst_in[11] || cond) nxt = target;
                OP_CALL:   begin call_req = 1'b1; nxt = target; end
                OP_RET:    begin ret_req = 1'b1; nxt = pop_data; end
                OP_DECODE: begin
                    exc_take = exc_req;
                    nxt      = exc_req ? exc_vec : dec_addr;
                end
                OP_HALT:   begin halt_req = 1'b1; nxt = upc; end
                default:   nxt = upc_inc;
            endcase
        end
    end

    assign i_fetch = clk_ena && (state == ST_RUN);
    assign exc_ack = i_fetch && exc_take;

    always_comb begin
        rom_addr = upc;
        if (clk_ena) begin
            case (state)
                ST_RESET: rom_addr = RST_VEC;
                ST_PRIME: rom_addr = RST_VEC;
                ST_RUN:   rom_addr = nxt;
                ST_HALT:  rom_addr = resume ? upc_inc : upc;
                default:  rom_addr = upc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RESET;
            upc   <= RST_VEC;
        end else if (clk_ena) begin
            upc <= rom_addr;
            case (state)
                ST_RESET: state <= ST_PRIME;
                ST_PRIME: state <= ST_RUN;
                ST_RUN:   if (halt_req && !loop_branch) state <= ST_HALT;
                ST_HALT:  if (resume) state <= ST_RUN;
                default:  state <= ST_RESET;
            endcase
        end
    end

    j68_rstack #(
        .DEPTH   (STK_DEPTH),
        .RST_VEC (RST_VEC)
    ) u_rstack (
        .clk       (clk),
        .rst       (rst),
        .push      (i_fetch && call_req),
        .pop       (i_fetch && ret_req),
        .push_data (upc_inc),
        .pop_data  (pop_data),
        .full      (stk_full),
        .empty     (stk_empty),
        .err       (stk_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_j68_useq.sv
// ============================================================================
// tb_j68_useq
// Directed self-checking bench for the j68 microcode sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_j68_useq;

    localparam logic [19:0] I_SEQ  = 20'hC0000;
    localparam logic [19:0] I_CALL = 20'h40000;
    localparam logic [19:0] I_RET  = 20'h60000;
    localparam logic [19:0] I_DEC  = 20'h80000;
    localparam logic [19:0] I_HALT = 20'hA0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_ena = 1'b1;
    logic [19:0] inst_in = 20'hC0000;
    logic        loop_branch = 1'b0;
    logic        loop_skip = 1'b0;
    logic [10:0] loop_pc = 11'h000;
    logic [10:0] dec_addr = 11'h000;
    logic        cond = 1'b0;
    logic        exc_req = 1'b0;
    logic [10:0] exc_vec = 11'h000;
    logic        resume = 1'b0;
    logic [10:0] rom_addr;
    logic [10:0] upc;
    logic        i_fetch;
    logic        exc_ack;
    logic        stk_err;

    int nvec = 0;
    int nerr = 0;

    j68_useq #(.STK_DEPTH(8), .RST_VEC(11'h000)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_ena     (clk_ena),
        .inst_in     (inst_in),
        .loop_branch (loop_branch),
        .loop_skip   (loop_skip),
        .loop_pc     (loop_pc),
        .dec_addr    (dec_addr),
        .cond        (cond),
        .exc_req     (exc_req),
        .exc_vec     (exc_vec),
        .resume      (resume),
        .rom_addr    (rom_addr),
        .upc         (upc),
        .i_fetch     (i_fetch),
        .exc_ack     (exc_ack),
        .stk_err     (stk_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reprime();
        inst_in = I_SEQ;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        // Reset state
        cyc();
        #1;
        chk("rst_upc", 32'(upc), 32'h000);
        chk("rst_rom", 32'(rom_addr), 32'h000);
        chk("rst_fetch", 32'(i_fetch), 32'd0);
        chk("rst_ack", 32'(exc_ack), 32'd0);
        chk("rst_err", 32'(stk_err), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("c1_rom", 32'(rom_addr), 32'h000);
        chk("c1_fetch", 32'(i_fetch), 32'd0);
        cyc(); #1;
        chk("c2_rom", 32'(rom_addr), 32'h000);
        chk("c2_fetch", 32'(i_fetch), 32'd0);
        cyc(); #1;
        chk("c3_fetch", 32'(i_fetch), 32'd1);
        chk("c3_upc", 32'(upc), 32'h000);
        chk("c3_rom", 32'(rom_addr), 32'h001);
        cyc(); #1;
        chk("seq_upc1", 32'(upc), 32'h001);
        cyc(); #1;
        chk("seq_upc2", 32'(upc), 32'h002);

        // Conditional and unconditional jumps
        inst_in = 20'h20923; cond = 1'b0; #1;
        chk("jcc_nt_rom", 32'(rom_addr), 32'h003);
        cyc(); #1;
        chk("jcc_nt_upc", 32'(upc), 32'h003);
        cond = 1'b1; #1;
        chk("jcc_t_rom", 32'(rom_addr), 32'h123);
        cyc(); #1;
        chk("jcc_t_upc", 32'(upc), 32'h123);
        inst_in = 20'h207FF; cond = 1'b0; #1;
        cyc(); #1;
        chk("jmp_7ff_upc", 32'(upc), 32'h7FF);
        inst_in = I_SEQ; #1;
        chk("wrap_rom", 32'(rom_addr), 32'h000);
        cyc(); #1;
        chk("wrap_upc", 32'(upc), 32'h000);

        // CALL / RET
        inst_in = 20'h20010;
        cyc(); #1;
        chk("jmp_010", 32'(upc), 32'h010);
        inst_in = I_CALL | 20'h050;
        cyc(); #1;
        chk("call_upc", 32'(upc), 32'h050);
        inst_in = I_RET; #1;
        chk("ret_rom", 32'(rom_addr), 32'h011);
        cyc(); #1;
        chk("ret_upc", 32'(upc), 32'h011);

        // Loop branch over a CALL, then LOOP skip
        inst_in = I_CALL | 20'h050; loop_branch = 1'b1; loop_pc = 11'h020; #1;
        chk("lb_rom", 32'(rom_addr), 32'h020);
        cyc(); #1;
        loop_branch = 1'b0;
        chk("lb_upc", 32'(upc), 32'h020);
        inst_in = 20'h00030; loop_skip = 1'b1; #1;
        chk("skip_rom", 32'(rom_addr), 32'h031);
        cyc(); #1;
        loop_skip = 1'b0;
        chk("skip_upc", 32'(upc), 32'h031);
        chk("pre_uf_err", 32'(stk_err), 32'd0);
        // Stack must be empty: no push happened under the loop branch
        inst_in = I_RET; #1;
        chk("uf_rom", 32'(rom_addr), 32'h000);
        cyc(); #1;
        chk("uf_upc", 32'(upc), 32'h000);
        chk("uf_err", 32'(stk_err), 32'd1);

        // Mid-run reset
        inst_in = I_SEQ; rst = 1'b1; #1;
        chk("mrst_err", 32'(stk_err), 32'd0);
        chk("mrst_fetch", 32'(i_fetch), 32'd0);
        chk("mrst_upc", 32'(upc), 32'h000);
        cyc();
        rst = 1'b0;
        cyc();
        cyc(); #1;
        chk("mrst_run", 32'(i_fetch), 32'd1);

        // Nine nested CALLs overflow an 8-deep stack
        for (int i = 0; i < 9; i++) begin
            inst_in = I_CALL | (20'h100 + 20'(i));
            cyc();
            if (i == 7) begin
                #1;
                chk("of8_err", 32'(stk_err), 32'd0);
            end
        end
        #1;
        chk("of9_upc", 32'(upc), 32'h108);
        chk("of9_err", 32'(stk_err), 32'd1);
        inst_in = I_RET; #1;
        chk("of_ret1", 32'(rom_addr), 32'h108);
        cyc(); #1;
        chk("of_ret2", 32'(rom_addr), 32'h106);
        reprime();

        // DECODE
        inst_in = I_DEC; dec_addr = 11'h2A0; exc_vec = 11'h700; exc_req = 1'b0; #1;
        chk("dec_rom", 32'(rom_addr), 32'h2A0);
        chk("dec_ack", 32'(exc_ack), 32'd0);
        cyc(); #1;
        chk("dec_upc", 32'(upc), 32'h2A0);
        exc_req = 1'b1; #1;
        chk("exc_rom", 32'(rom_addr), 32'h700);
        chk("exc_ack1", 32'(exc_ack), 32'd1);
        cyc();
        inst_in = I_SEQ; #1;
        chk("exc_upc", 32'(upc), 32'h700);
        chk("exc_ack0", 32'(exc_ack), 32'd0);
        chk("exc_ign_rom", 32'(rom_addr), 32'h701);
        exc_req = 1'b0;

        // HALT
        inst_in = I_HALT; #1;
        chk("halt_rom", 32'(rom_addr), 32'h700);
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            chk("halt_upc", 32'(upc), 32'h700);
            chk("halt_fetch", 32'(i_fetch), 32'd0);
        end
        resume = 1'b1; #1;
        chk("resume_rom", 32'(rom_addr), 32'h701);
        cyc();
        resume = 1'b0; inst_in = I_SEQ; #1;
        chk("resume_upc", 32'(upc), 32'h701);
        chk("resume_fetch", 32'(i_fetch), 32'd1);

        // Clock enable toggled every other cycle
        for (int i = 0; i < 3; i++) begin
            clk_ena = 1'b0; #1;
            chk("ce0_fetch", 32'(i_fetch), 32'd0);
            chk("ce0_rom", 32'(rom_addr), 32'(11'h701 + 11'(i)));
            cyc();
            clk_ena = 1'b1; #1;
            chk("ce0_hold", 32'(upc), 32'(11'h701 + 11'(i)));
            cyc(); #1;
            chk("ce1_upc", 32'(upc), 32'(11'h702 + 11'(i)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
